// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode constants and fetch-stage shared types
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order fifo with synchronous flush, push/pop legal in the same cycle when full
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, credit-limited imem requests, instruction buffer, redirect flush
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] tag_count;
  logic [CW:0]   credit_used;
  logic          buf_full, buf_empty, tag_full, tag_empty;
  logic [31:0]   tag_pc;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_in;
  logic          grant, pop, accept;

  assign grant  = imem_req & imem_gnt;
  assign pop    = if_valid & id_ready & ~redirect_valid;
  // Responses owed to a pre-redirect request are consumed by drop, never buffered.
  assign accept = imem_rvalid & (drop == '0) & ~redirect_valid;

  // In-flight requests plus buffered entries may never exceed the buffer size.
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
  assign imem_req    = ~rst & (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr   = pc;

  assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);
  assign buf_in           = '{instr: imem_rdata, pc: tag_pc};

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (grant & ~redirect_valid),
    .push_data (pc),
    .pop       (accept),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (buf_in),
    .pop       (pop),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign if_valid = ~rst & ~buf_empty;
  assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
  assign if_pc    = if_valid ? buf_head.pc : RESET_PC;
  assign opcode   = if_instr[6:0];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc   <= redirect_pc & ~32'h3;
        drop <= outstanding_next;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  a_rvalid_idle:   assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && outstanding == '0));
  a_buf_overflow:  assert property (@(posedge clk) disable iff (rst) !(accept && buf_full && !pop));
  a_tag_overflow:  assert property (@(posedge clk) disable iff (rst) !(grant && tag_full));
  a_tag_underflow: assert property (@(posedge clk) disable iff (rst) !(accept && tag_empty));
  a_tag_count:     assert property (@(posedge clk) disable iff (rst) tag_count <= outstanding);

endmodule
